// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared constants, state type and timing helper for the WS2812
// receive path.
//   WS_BITS_PER_LED  bits per GRB word
//   ws_state_t       receiver frame state
//   ns_to_cycles()   ceil(ns * clk_hz / 1e9)
//   WS_*_CYC         derived cycle counts at the default 50 MHz clock
package ws2812_pkg;

  localparam int unsigned WS_BITS_PER_LED = 24;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    HIGH,
    LOW
  } ws_state_t;

  function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                               input longint unsigned clk_hz);
    longint unsigned prod;
    prod = ns * clk_hz + 64'd999_999_999;
    return 32'(prod / 64'd1_000_000_000);
  endfunction

  localparam int unsigned WS_SPLIT_CYC    = ns_to_cycles(625, 50_000_000);
  localparam int unsigned WS_MIN_HIGH_CYC = ns_to_cycles(100, 50_000_000);
  localparam int unsigned WS_MAX_HIGH_CYC = ns_to_cycles(1500, 50_000_000);
  localparam int unsigned WS_LATCH_CYC    = ns_to_cycles(50000, 50_000_000);

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer for an asynchronous input followed by a
// delay flop, producing the synchronized level and single-cycle edge strobes.
//   clk_i    system clock
//   reset_i  synchronous, active-high reset
//   din_i    asynchronous input
//   din_s_o  synchronized level
//   rise_o   high for one cycle when din_s_o goes 0 -> 1
//   fall_o   high for one cycle when din_s_o goes 1 -> 0
module sync_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic din_i,
  output logic din_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= din_i;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign din_s_o = r_sync;
  assign rise_o  = r_sync & ~r_dly;
  assign fall_o  = ~r_sync & r_dly;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 NRZ stream into 24-bit GRB words by measuring
// high-pulse widths, detects the latch gap ending a frame, and reports frame
// statistics and timing errors.
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   din_i         asynchronous serial input
//   data_o        last decoded word, bit 23 received first
//   index_o       LED index of data_o within the frame
//   valid_o       one-cycle strobe qualifying data_o/index_o
//   frame_done_o  one-cycle strobe on latch gap
//   word_count_o  complete words in the last frame (saturates at NUM_LEDS+1)
//   overflow_o    more than NUM_LEDS words in the current frame
//   err_o         one-cycle strobe on timing error or partial word at latch
//   busy_o        frame in progress
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned SYSTEM_CLOCK  = 50_000_000,
  parameter int unsigned T_SPLIT_NS    = 625,
  parameter int unsigned T_MIN_HIGH_NS = 100,
  parameter int unsigned T_MAX_HIGH_NS = 1500,
  parameter int unsigned T_LATCH_NS    = 50000
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           din_i,
  output logic [WS_BITS_PER_LED-1:0]     data_o,
  output logic [$clog2(NUM_LEDS)-1:0]    index_o,
  output logic                           valid_o,
  output logic                           frame_done_o,
  output logic [$clog2(NUM_LEDS):0]      word_count_o,
  output logic                           overflow_o,
  output logic                           err_o,
  output logic                           busy_o
);

  localparam int unsigned SPLIT_CYC = ns_to_cycles(T_SPLIT_NS, SYSTEM_CLOCK);
  localparam int unsigned MIN_CYC   = ns_to_cycles(T_MIN_HIGH_NS, SYSTEM_CLOCK);
  localparam int unsigned MAX_CYC   = ns_to_cycles(T_MAX_HIGH_NS, SYSTEM_CLOCK);
  localparam int unsigned LATCH_CYC = ns_to_cycles(T_LATCH_NS, SYSTEM_CLOCK);

  localparam int unsigned IW = $clog2(NUM_LEDS);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned HW = $clog2(MAX_CYC + 2);
  localparam int unsigned LW = $clog2(LATCH_CYC + 1);
  localparam int unsigned BW = $clog2(WS_BITS_PER_LED + 1);

  localparam logic [HW-1:0] HI_SPLIT  = HW'(SPLIT_CYC);
  localparam logic [HW-1:0] HI_MIN    = HW'(MIN_CYC);
  localparam logic [HW-1:0] HI_MAX    = HW'(MAX_CYC);
  localparam logic [HW-1:0] HI_SAT    = HW'(MAX_CYC + 1);
  localparam logic [LW-1:0] LO_LATCH  = LW'(LATCH_CYC);
  localparam logic [CW-1:0] WC_LEDS   = CW'(NUM_LEDS);
  localparam logic [CW-1:0] WC_SAT    = CW'(NUM_LEDS + 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(WS_BITS_PER_LED);

  logic w_din_s;
  logic w_rise;
  logic w_fall;

  sync_edge_det u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .din_i   (din_i),
    .din_s_o (w_din_s),
    .rise_o  (w_rise),
    .fall_o  (w_fall)
  );

  ws_state_t                  r_state;
  logic [HW-1:0]              r_hi_cnt;
  logic [LW-1:0]              r_lo_cnt;
  logic [BW-1:0]              r_bit_cnt;
  logic [CW-1:0]              r_wcnt;
  logic [WS_BITS_PER_LED-1:0] r_shift;
  logic                       r_pend_valid;
  logic [WS_BITS_PER_LED-1:0] r_pend_word;
  logic [IW-1:0]              r_pend_idx;
  logic [WS_BITS_PER_LED-1:0] r_data;
  logic [IW-1:0]              r_index;
  logic                       r_valid;
  logic                       r_frame_done;
  logic [CW-1:0]              r_word_count;
  logic                       r_overflow;
  logic                       r_err;
  logic                       r_busy;

  logic [LW-1:0] w_lo_next;
  logic          w_lo_latch;

  // Latch fires on the LATCH-th consecutive low cycle itself, so a rise right
  // after LATCH-1 low cycles still continues the frame.
  always_comb begin
    w_lo_next = '0;
    if (!w_din_s) begin
      w_lo_next = (r_lo_cnt == LO_LATCH) ? r_lo_cnt : r_lo_cnt + 1'b1;
    end
    w_lo_latch = !w_din_s && (w_lo_next == LO_LATCH);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= WAIT_IDLE;
      r_hi_cnt     <= '0;
      r_lo_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_wcnt       <= '0;
      r_shift      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_word  <= '0;
      r_pend_idx   <= '0;
      r_data       <= '0;
      r_index      <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;

      // Output stage: the completed word is staged for one cycle before it
      // reaches data_o/valid_o.
      r_valid      <= r_pend_valid;
      r_pend_valid <= 1'b0;
      if (r_pend_valid) begin
        r_data  <= r_pend_word;
        r_index <= r_pend_idx;
      end

      if (w_din_s) begin
        if (w_rise) begin
          r_hi_cnt <= HW'(1);
        end else if (r_hi_cnt != HI_SAT) begin
          r_hi_cnt <= r_hi_cnt + 1'b1;
        end
        r_lo_cnt <= '0;
      end else begin
        r_lo_cnt <= w_lo_next;
      end

      // Word completion runs the cycle after the 24th bit was shifted in.
      if (r_bit_cnt == BITS_FULL) begin
        r_bit_cnt <= '0;
        if (r_wcnt < WC_LEDS) begin
          r_pend_valid <= 1'b1;
          r_pend_word  <= r_shift;
          r_pend_idx   <= r_wcnt[IW-1:0];
        end else begin
          r_overflow <= 1'b1;
        end
        if (r_wcnt != WC_SAT) begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end

      case (r_state)
        WAIT_IDLE: begin
          if (w_lo_latch) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_rise) begin
            r_bit_cnt  <= '0;
            r_wcnt     <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= HIGH;
          end
        end
        HIGH: begin
          if (r_hi_cnt > HI_MAX) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= WAIT_IDLE;
          end else if (w_fall) begin
            if (r_hi_cnt < HI_MIN) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= WAIT_IDLE;
            end else begin
              r_shift   <= {r_shift[WS_BITS_PER_LED-2:0], (r_hi_cnt >= HI_SPLIT)};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_state   <= LOW;
            end
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
          end else if (w_lo_latch) begin
            r_frame_done <= 1'b1;
            r_word_count <= r_wcnt;
            r_err        <= (r_bit_cnt != '0);
            r_busy       <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

  assign data_o       = r_data;
  assign index_o      = r_index;
  assign valid_o      = r_valid;
  assign frame_done_o = r_frame_done;
  assign word_count_o = r_word_count;
  assign overflow_o   = r_overflow;
  assign err_o        = r_err;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed self-checking bench for ws2812_rx at 50 MHz.
module tb_ws2812_rx;

  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b1;
  logic        din_i   = 1'b0;
  logic [23:0] data_o;
  logic [2:0]  index_o;
  logic        valid_o;
  logic        frame_done_o;
  logic [3:0]  word_count_o;
  logic        overflow_o;
  logic        err_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  // Event log filled on negedges; the stimulus block only reads it.
  logic [23:0] v_data [0:255];
  logic [2:0]  v_idx  [0:255];
  logic [3:0]  d_wc   [0:255];
  logic        d_err  [0:255];
  int n_valid = 0;
  int n_done  = 0;
  int n_err   = 0;

  ws2812_rx #(
    .NUM_LEDS      (8),
    .SYSTEM_CLOCK  (50_000_000),
    .T_SPLIT_NS    (625),
    .T_MIN_HIGH_NS (100),
    .T_MAX_HIGH_NS (1500),
    .T_LATCH_NS    (50000)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .din_i        (din_i),
    .data_o       (data_o),
    .index_o      (index_o),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o),
    .word_count_o (word_count_o),
    .overflow_o   (overflow_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  always #10 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (valid_o) begin
      v_data[n_valid & 255] = data_o;
      v_idx[n_valid & 255]  = index_o;
      n_valid++;
    end
    if (frame_done_o) begin
      d_wc[n_done & 255]  = word_count_o;
      d_err[n_done & 255] = err_o;
      n_done++;
    end
    if (err_o) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    din_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bit_pulse(input int hi, input int lo);
    din_i = 1'b1;
    repeat (hi) @(negedge clk_i);
    din_i = 1'b0;
    repeat (lo) @(negedge clk_i);
  endtask

  // 1 = 40 high / 23 low, 0 = 20 high / 43 low; last_lo != 0 overrides the
  // low time after bit 0.
  task automatic send_word(input logic [23:0] w, input int last_lo);
    for (int i = 23; i >= 0; i--) begin
      int lo;
      lo = w[i] ? 23 : 43;
      if (i == 0 && last_lo != 0) lo = last_lo;
      bit_pulse(w[i] ? 40 : 20, lo);
    end
  endtask

  initial begin
    int bv;
    int bd;
    int be;
    logic [23:0] w;

    // Reset state
    repeat (5) @(negedge clk_i);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_index", 32'(index_o), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_done", 32'(frame_done_o), 32'h0);
    check("rst_wc", 32'(word_count_o), 32'h0);
    check("rst_ovf", 32'(overflow_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    reset_i = 1'b0;
    idle(2600);

    // Single word 0xFF00A5 with latency check on the final bit
    bv = n_valid; bd = n_done; be = n_err;
    w = 24'hFF00A5;
    for (int i = 23; i >= 1; i--) begin
      bit_pulse(w[i] ? 40 : 20, w[i] ? 23 : 43);
      if (i == 12) check("busy_mid", 32'(busy_o), 32'h1);
    end
    din_i = 1'b1;
    repeat (40) @(negedge clk_i);
    din_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 check("lat_early", 32'(valid_o), 32'h0);
    @(posedge clk_i);
    #1 check("lat_valid", 32'(valid_o), 32'h1);
    check("lat_data", 32'(data_o), 32'hFF00A5);
    check("lat_index", 32'(index_o), 32'h0);
    @(negedge clk_i);
    idle(3000);
    check("w1_nvalid", 32'(n_valid - bv), 32'd1);
    check("w1_ndone", 32'(n_done - bd), 32'd1);
    check("w1_wc", 32'(d_wc[bd & 255]), 32'd1);
    check("w1_nerr", 32'(n_err - be), 32'd0);
    check("w1_busy_end", 32'(busy_o), 32'h0);

    // Eight words fill the frame exactly
    bv = n_valid; bd = n_done; be = n_err;
    for (int k = 1; k <= 8; k++) send_word(24'(k), (k == 8) ? 2600 : 0);
    check("f8_nvalid", 32'(n_valid - bv), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("f8_data", 32'(v_data[(bv + k) & 255]), 32'(k + 1));
      check("f8_idx", 32'(v_idx[(bv + k) & 255]), 32'(k));
    end
    check("f8_wc", 32'(d_wc[bd & 255]), 32'd8);
    check("f8_ovf", 32'(overflow_o), 32'h0);
    check("f8_nerr", 32'(n_err - be), 32'd0);

    // Nine words overflow
    bv = n_valid; bd = n_done;
    for (int k = 1; k <= 9; k++) send_word(24'(k), (k == 9) ? 2600 : 0);
    check("f9_nvalid", 32'(n_valid - bv), 32'd8);
    check("f9_last_data", 32'(v_data[(bv + 7) & 255]), 32'h8);
    check("f9_wc", 32'(d_wc[bd & 255]), 32'd9);
    check("f9_ovf", 32'(overflow_o), 32'h1);

    // Threshold boundaries: 32 -> 1, 31 -> 0; 75 and 5 are legal
    bv = n_valid; bd = n_done; be = n_err;
    for (int i = 23; i >= 0; i--) bit_pulse((i % 2 == 1) ? 32 : 31, 30);
    for (int i = 23; i >= 0; i--) bit_pulse((i == 23) ? 75 : 5, (i == 0) ? 2600 : 30);
    check("thr_nvalid", 32'(n_valid - bv), 32'd2);
    check("thr_split", 32'(v_data[bv & 255]), 32'hAAAAAA);
    check("thr_minmax", 32'(v_data[(bv + 1) & 255]), 32'h800000);
    check("thr_wc", 32'(d_wc[bd & 255]), 32'd2);
    check("thr_nerr", 32'(n_err - be), 32'd0);
    check("thr_ovf_clr", 32'(overflow_o), 32'h0);

    // Glitch of 4 cycles
    bv = n_valid; bd = n_done; be = n_err;
    bit_pulse(4, 30);
    idle(2600);
    check("gl_nerr", 32'(n_err - be), 32'd1);
    check("gl_nvalid", 32'(n_valid - bv), 32'd0);
    check("gl_ndone", 32'(n_done - bd), 32'd0);

    // 76-cycle high: error, then the following word is ignored
    bv = n_valid; bd = n_done; be = n_err;
    bit_pulse(76, 10);
    send_word(24'h00FFFF, 2600);
    check("long_nerr", 32'(n_err - be), 32'd1);
    check("long_nvalid", 32'(n_valid - bv), 32'd0);
    check("long_ndone", 32'(n_done - bd), 32'd0);
    bv = n_valid; bd = n_done;
    send_word(24'h5A5A5A, 2600);
    check("rec_nvalid", 32'(n_valid - bv), 32'd1);
    check("rec_data", 32'(v_data[bv & 255]), 32'h5A5A5A);
    check("rec_wc", 32'(d_wc[bd & 255]), 32'd1);

    // Partial word (12 bits) at latch
    bv = n_valid; bd = n_done; be = n_err;
    for (int i = 0; i < 12; i++) bit_pulse(40, (i == 11) ? 2600 : 23);
    check("part_ndone", 32'(n_done - bd), 32'd1);
    check("part_err_at_done", 32'(d_err[bd & 255]), 32'h1);
    check("part_wc", 32'(d_wc[bd & 255]), 32'd0);
    check("part_nvalid", 32'(n_valid - bv), 32'd0);
    check("part_nerr", 32'(n_err - be), 32'd1);

    // Gap of 2499 low cycles keeps one frame
    bv = n_valid; bd = n_done; be = n_err;
    send_word(24'h111111, 2499);
    send_word(24'h222222, 2600);
    check("g2499_ndone", 32'(n_done - bd), 32'd1);
    check("g2499_wc", 32'(d_wc[bd & 255]), 32'd2);
    check("g2499_data1", 32'(v_data[(bv + 1) & 255]), 32'h222222);
    check("g2499_idx1", 32'(v_idx[(bv + 1) & 255]), 32'd1);

    // Gap of 2500 low cycles splits into two frames
    bv = n_valid; bd = n_done;
    send_word(24'h333333, 2500);
    send_word(24'h444444, 2600);
    check("g2500_ndone", 32'(n_done - bd), 32'd2);
    check("g2500_wc0", 32'(d_wc[bd & 255]), 32'd1);
    check("g2500_wc1", 32'(d_wc[(bd + 1) & 255]), 32'd1);
    check("g2500_idx1", 32'(v_idx[(bv + 1) & 255]), 32'd0);
    check("g2500_data1", 32'(v_data[(bv + 1) & 255]), 32'h444444);
    check("gap_nerr", 32'(n_err - be), 32'd0);

    // Reset in the middle of word 3
    send_word(24'hABCDEF, 0);
    send_word(24'h123456, 0);
    for (int i = 0; i < 10; i++) bit_pulse(40, 23);
    din_i = 1'b1;
    repeat (10) @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("mrst_data", 32'(data_o), 32'h0);
    check("mrst_index", 32'(index_o), 32'h0);
    check("mrst_valid", 32'(valid_o), 32'h0);
    check("mrst_done", 32'(frame_done_o), 32'h0);
    check("mrst_wc", 32'(word_count_o), 32'h0);
    check("mrst_ovf", 32'(overflow_o), 32'h0);
    check("mrst_err", 32'(err_o), 32'h0);
    check("mrst_busy", 32'(busy_o), 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    bd = n_done;
    idle(2600);
    check("mrst_ndone", 32'(n_done - bd), 32'd0);
    bv = n_valid; bd = n_done;
    send_word(24'hC0FFEE, 2600);
    check("post_nvalid", 32'(n_valid - bv), 32'd1);
    check("post_data", 32'(v_data[bv & 255]), 32'hC0FFEE);
    check("post_idx", 32'(v_idx[bv & 255]), 32'd0);
    check("post_wc", 32'(d_wc[bd & 255]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
Decodes a WS2812 one-wire NRZ stream back into 24-bit per-LED words, which is the receive end of the neopixel transmitter's output. It is used for board-level loopback and self-test: the ws2812 do_o pin is fed to din_i. It measures high-pulse widths to recover bits and assembles them MSB-first into GRB words. It also detects the latch (reset) gap that ends a frame and reports frame statistics and errors.

Parameters:
NUM_LEDS, 8, maximum words accepted per frame; extra words are flagged as overflow
SYSTEM_CLOCK, 50000000, clk_i frequency in Hz
T_SPLIT_NS, 625, high-time threshold: high >= threshold decodes as 1, otherwise 0
T_MIN_HIGH_NS, 100, high pulses shorter than this are glitches and flag an error
T_MAX_HIGH_NS, 1500, high pulses longer than this flag an error
T_LATCH_NS, 50000, low time that ends a frame

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
din_i  in  1  asynchronous WS2812 serial input
data_o  out  24  last decoded word, GRB order, bit 23 is the first bit received
index_o  out  $clog2(NUM_LEDS)  LED index of data_o within the current frame
valid_o  out  1  one-cycle pulse; data_o and index_o are valid in this cycle
frame_done_o  out  1  one-cycle pulse when the latch gap is detected
word_count_o  out  $clog2(NUM_LEDS)+1  complete words in the frame; updated with frame_done_o
overflow_o  out  1  sticky within a frame: more than NUM_LEDS words were received; cleared at the next frame start
err_o  out  1  one-cycle pulse on a timing error or a partial word at latch
busy_o  out  1  high from the first rising edge of a frame until frame_done_o

Behaviour:
- Cycle constants are computed as ceil(T_x_NS * SYSTEM_CLOCK / 1e9). At 50 MHz: SPLIT=32, MIN_HIGH=5, MAX_HIGH=75, LATCH=2500.
- din_i passes through a 2-flop synchronizer plus one delay flop to give din_s and din_d.
  - Rise is din_s & ~din_d; fall is ~din_s & din_d.
- Reset values: all outputs 0, all counters 0, state WAIT_IDLE.
- Counters:
  - hi_cnt counts cycles with din_s high, starting at 1 on the rise cycle, and saturates at MAX_HIGH+1.
  - lo_cnt counts cycles with din_s low and saturates at LATCH.
- States:
  - WAIT_IDLE: line must stay low for LATCH consecutive cycles, then go to IDLE. Any high restarts the count. This state absorbs traffic already in progress after reset or an error.
  - IDLE: on rise, clear bit_cnt, word index, overflow_o; set busy_o; go to HIGH.
  - HIGH: on fall, check hi_cnt.
    - If hi_cnt < MIN_HIGH: pulse err_o, drop busy_o, go to WAIT_IDLE.
    - Otherwise shift in bit = (hi_cnt >= SPLIT) and go to LOW.
    - If hi_cnt exceeds MAX_HIGH while still high: pulse err_o in that cycle, drop busy_o, go to WAIT_IDLE.
  - LOW: on rise, go to HIGH.
    - When lo_cnt reaches LATCH, pulse frame_done_o and load word_count_o with the completed word count. Also pulse err_o in the same cycle if bit_cnt != 0.
    - Then drop busy_o, go to IDLE, and discard the partial shift register.
- Word completion: when the 24th bit is shifted in, in the cycle after the fall is detected:
  - If index < NUM_LEDS: data_o <= shift word, index_o <= index, valid_o = 1.
  - Otherwise: set overflow_o, no valid_o, data_o unchanged.
  - In both cases, increment the word count, saturating at NUM_LEDS+1.
- Latency: valid_o asserts exactly 4 clk_i cycles after the first clk_i edge that samples din_i low at the end of bit 23.
- Boundaries:
  - hi_cnt == SPLIT decodes 1; hi_cnt == SPLIT-1 decodes 0.
  - hi_cnt == MAX_HIGH is legal; MAX_HIGH+1 is an error.
  - lo_cnt == LATCH-1 followed by a rise continues the frame.
  - On overflow, word_count_o reports NUM_LEDS+1 saturated.
- reset_i asserted mid-frame: all state clears next cycle, no frame_done_o, return to WAIT_IDLE.

Decomposition:
- Package ws2812_pkg holds:
  - ns-to-cycle conversion function and derived constants (SPLIT, MIN_HIGH, MAX_HIGH, LATCH cycles)
  - state enum {WAIT_IDLE, IDLE, HIGH, LOW}
  - WS_BITS_PER_LED = 24
- Sub-module sync_edge_det (2-flop synchronizer plus rise/fall pulses) is shared with the SPI front end.

Test Plan:
- Hold din_i low for 2600 cycles after reset, then send one word 0xFF00A5 (bit 1: 800 ns high/450 ns low; bit 0: 400 ns high/850 ns low), then 60 us low -> valid_o once, data_o=0xFF00A5, index_o=0, then frame_done_o, word_count_o=1, err_o never set.
- Send 8 words 0x000001..0x000008 then latch -> 8 valid_o pulses with index_o 0..7 and matching data, word_count_o=8, overflow_o=0. Repeat with 9 words -> 8 valid_o, overflow_o=1, word_count_o=9.
- Threshold sweep with high = 31 and 32 cycles -> bits decode 0 and 1 respectively. High = 4 cycles -> err_o, no valid_o. High = 76 cycles -> err_o; the next frame is ignored until 2500 low cycles have elapsed.
- Send 12 bits then latch -> frame_done_o with err_o in the same cycle, word_count_o=0, no valid_o.
- Low gap of 2499 cycles between words -> single frame, word_count_o=2. Low gap of 2500 cycles -> two frames, each with word_count_o=1.
- Assert reset_i in the middle of word 3 -> all outputs 0 the next cycle, no frame_done_o. A subsequent clean frame decodes correctly.
